// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: FSM states, bus/load
// select codes, opcodes, ALU operation codes and the register-to-code map.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_T3    = 3'd4,
        ST_T4    = 3'd5,
        ST_T5    = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    localparam logic [4:0] SEL_NONE = 5'd0;
    localparam logic [4:0] SEL_ZLOW = 5'd19;
    localparam logic [4:0] SEL_PC   = 5'd20;
    localparam logic [4:0] SEL_MDR  = 5'd21;
    localparam logic [4:0] SEL_IR   = 5'd23;
    localparam logic [4:0] SEL_Z    = 5'd24;
    localparam logic [4:0] SEL_MAR  = 5'd25;
    localparam logic [4:0] SEL_R0   = 5'd26;
    localparam logic [4:0] SEL_Y    = 5'd27;

    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_AND = 5'h05;
    localparam logic [4:0] OP_OR  = 5'h06;
    localparam logic [4:0] OP_SHL = 5'h07;
    localparam logic [4:0] OP_SHR = 5'h08;
    localparam logic [4:0] OP_ROR = 5'h09;
    localparam logic [4:0] OP_ROL = 5'h0A;
    localparam logic [4:0] OP_NOT = 5'h0B;
    localparam logic [4:0] OP_NEG = 5'h0C;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_ROR = 4'd7;
    localparam logic [3:0] ALU_ROL = 4'd8;
    localparam logic [3:0] ALU_NOT = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;

    // R1-R15 select with their own number; R0 lives at a separate code.
    function automatic logic [4:0] reg_code(input logic [3:0] r);
        return (r == 4'd0) ? SEL_R0 : {1'b0, r};
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Opcode decoder: ALU operation, unary flag and illegal-opcode flag.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [3:0] alu_op,
    output logic       unary,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_NOP;
        unary   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD: alu_op = ALU_ADD;
            OP_SUB: alu_op = ALU_SUB;
            OP_AND: alu_op = ALU_AND;
            OP_OR:  alu_op = ALU_OR;
            OP_SHL: alu_op = ALU_SHL;
            OP_SHR: alu_op = ALU_SHR;
            OP_ROR: alu_op = ALU_ROR;
            OP_ROL: alu_op = ALU_ROL;
            OP_NOT: begin
                alu_op = ALU_NOT;
                unary  = 1'b1;
            end
            OP_NEG: begin
                alu_op = ALU_NEG;
                unary  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T5 fetch/execute sequencer for register-to-register ALU
// instructions; all control outputs are registered Moore outputs.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic          mem_ready,
    input  logic [DW-1:0] ir,
    output logic [DW-1:0] enable,
    output logic [DW-1:0] busSelect,
    output logic          MD_Read,
    output logic          pc_inc,
    output logic [3:0]    Control_Signals,
    output logic          done,
    output logic          fault
);

    state_t      state;
    logic [4:0]  en_code;
    logic [4:0]  bus_code;
    logic [31:15] ir_f;

    logic [4:0]  dec_opcode;
    logic [3:0]  dec_alu;
    logic        dec_unary;
    logic        dec_illegal;
    logic        unused_ir;

    assign unused_ir = ^ir[14:0];

    // The T3 outputs are prepared on the T2->T3 edge from the live IR value,
    // which is also captured there; T3/T4/T5 then work from the captured copy.
    assign dec_opcode = (state == ST_T2) ? ir[31:27] : ir_f[31:27];

    instr_decode u_decode (
        .opcode  (dec_opcode),
        .alu_op  (dec_alu),
        .unary   (dec_unary),
        .illegal (dec_illegal)
    );

    assign enable    = {{(DW-5){1'b0}}, en_code};
    assign busSelect = {{(DW-5){1'b0}}, bus_code};

    // Handshake: mem_ready acts as a data-valid strobe for MDataIn; the
    // sequencer holds its T1 read request until it samples mem_ready high.
    always_ff @(posedge clk) begin
        if (clr) begin
            state           <= ST_IDLE;
            en_code         <= SEL_NONE;
            bus_code        <= SEL_NONE;
            MD_Read         <= 1'b0;
            pc_inc          <= 1'b0;
            Control_Signals <= ALU_NOP;
            done            <= 1'b0;
            fault           <= 1'b0;
            ir_f            <= '0;
        end else begin
            en_code         <= SEL_NONE;
            bus_code        <= SEL_NONE;
            MD_Read         <= 1'b0;
            pc_inc          <= 1'b0;
            Control_Signals <= ALU_NOP;
            done            <= 1'b0;
            fault           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_T0;
                        bus_code <= SEL_PC;
                        en_code  <= SEL_MAR;
                        pc_inc   <= 1'b1;
                    end
                end
                ST_T0: begin
                    state   <= ST_T1;
                    en_code <= SEL_MDR;
                    MD_Read <= 1'b1;
                end
                ST_T1: begin
                    if (mem_ready) begin
                        state    <= ST_T2;
                        bus_code <= SEL_MDR;
                        en_code  <= SEL_IR;
                    end else begin
                        en_code <= SEL_MDR;
                        MD_Read <= 1'b1;
                    end
                end
                ST_T2: begin
                    state <= ST_T3;
                    ir_f  <= ir[31:15];
                    if (!dec_illegal && !dec_unary) begin
                        bus_code <= reg_code(ir[22:19]);
                        en_code  <= SEL_Y;
                    end
                end
                ST_T3: begin
                    if (dec_illegal) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        state           <= ST_T4;
                        en_code         <= SEL_Z;
                        Control_Signals <= dec_alu;
                        bus_code        <= dec_unary ? reg_code(ir_f[22:19])
                                                     : reg_code(ir_f[18:15]);
                    end
                end
                ST_T4: begin
                    state    <= ST_T5;
                    bus_code <= SEL_ZLOW;
                    en_code  <= reg_code(ir_f[26:23]);
                    done     <= 1'b1;
                end
                ST_T5: begin
                    if (run) begin
                        state    <= ST_T0;
                        bus_code <= SEL_PC;
                        en_code  <= SEL_MAR;
                        pc_inc   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    fault <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int DW = 32;
    localparam logic [31:0] IR_ADD = 32'h18A28000; // add R1,R4,R5
    localparam logic [31:0] IR_NOT = 32'h59380000; // not R2,R7
    localparam logic [31:0] IR_SUB = 32'h20078000; // sub R0,R0,R15
    localparam logic [31:0] IR_BAD = 32'hF8000000; // opcode 0x1F

    logic          clk;
    logic          clr;
    logic          run;
    logic          mem_ready;
    logic [DW-1:0] ir;
    logic [DW-1:0] enable;
    logic [DW-1:0] busSelect;
    logic          MD_Read;
    logic          pc_inc;
    logic [3:0]    Control_Signals;
    logic          done;
    logic          fault;

    int n_cmp;
    int n_bad;

    control_sequencer #(.DW(DW)) dut (
        .clk             (clk),
        .clr             (clr),
        .run             (run),
        .mem_ready       (mem_ready),
        .ir              (ir),
        .enable          (enable),
        .busSelect       (busSelect),
        .MD_Read         (MD_Read),
        .pc_inc          (pc_inc),
        .Control_Signals (Control_Signals),
        .done            (done),
        .fault           (fault)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        state_t      st;
        logic [31:0] en;
        logic [31:0] bus;
        logic        mdr;
        logic        pci;
        logic [3:0]  ctrl;
        logic        dn;
        logic        flt;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input string nm, input logic c, input logic r,
                              input logic m, input logic [31:0] i, input state_t s,
                              input logic [31:0] e, input logic [31:0] b,
                              input logic mdr, input logic pci, input logic [3:0] ctl,
                              input logic dn, input logic flt);
        vec_t x;
        x.name = nm; x.clr = c; x.run = r; x.mr = m; x.ir = i; x.st = s;
        x.en = e; x.bus = b; x.mdr = mdr; x.pci = pci; x.ctrl = ctl;
        x.dn = dn; x.flt = flt;
        vecs.push_back(x);
    endfunction

    // driver: apply one vector's inputs, clock once, compare registered outputs
    task automatic apply_and_check(input vec_t x, input int idx);
        clr       = x.clr;
        run       = x.run;
        mem_ready = x.mr;
        ir        = x.ir;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dut.state !== x.st || enable !== x.en || busSelect !== x.bus ||
            MD_Read !== x.mdr || pc_inc !== x.pci || Control_Signals !== x.ctrl ||
            done !== x.dn || fault !== x.flt) begin
            n_bad++;
            $display("FAIL %s[%0d]: got st=%0d en=%0d bus=%0d mdr=%b pci=%b ctrl=%0d done=%b fault=%b, want st=%0d en=%0d bus=%0d mdr=%b pci=%b ctrl=%0d done=%b fault=%b",
                     x.name, idx, dut.state, enable, busSelect, MD_Read, pc_inc,
                     Control_Signals, done, fault, x.st, x.en, x.bus, x.mdr,
                     x.pci, x.ctrl, x.dn, x.flt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;

        // reset: two clr cycles, then ten idle cycles with run low
        v("rst", 1, 0, 0, 32'h0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
        v("rst", 1, 0, 0, 32'h0, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            v("idle", 0, 0, 1, IR_ADD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

        // add R1,R4,R5 with memory immediately ready
        v("add_t0",   0, 1, 1, IR_ADD, ST_T0,   25, 20, 0, 1, 0, 0, 0);
        v("add_t1",   0, 0, 1, IR_ADD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("add_t2",   0, 0, 1, IR_ADD, ST_T2,   23, 21, 0, 0, 0, 0, 0);
        v("add_t3",   0, 0, 1, IR_ADD, ST_T3,   27,  4, 0, 0, 0, 0, 0);
        v("add_t4",   0, 0, 1, IR_ADD, ST_T4,   24,  5, 0, 0, 1, 0, 0);
        v("add_t5",   0, 0, 1, IR_ADD, ST_T5,    1, 19, 0, 0, 0, 1, 0);
        v("add_idle", 0, 0, 1, IR_ADD, ST_IDLE,  0,  0, 0, 0, 0, 0, 0);

        // same add with mem_ready low for three T1 cycles: 9-cycle instruction
        v("wt_t0",   0, 1, 0, IR_ADD, ST_T0,   25, 20, 0, 1, 0, 0, 0);
        v("wt_t1a",  0, 0, 0, IR_ADD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("wt_t1b",  0, 0, 0, IR_ADD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("wt_t1c",  0, 0, 0, IR_ADD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("wt_t1d",  0, 0, 0, IR_ADD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("wt_t2",   0, 0, 1, IR_ADD, ST_T2,   23, 21, 0, 0, 0, 0, 0);
        v("wt_t3",   0, 0, 1, IR_ADD, ST_T3,   27,  4, 0, 0, 0, 0, 0);
        v("wt_t4",   0, 0, 1, IR_ADD, ST_T4,   24,  5, 0, 0, 1, 0, 0);
        v("wt_t5",   0, 0, 1, IR_ADD, ST_T5,    1, 19, 0, 0, 0, 1, 0);
        v("wt_idle", 0, 0, 1, IR_ADD, ST_IDLE,  0,  0, 0, 0, 0, 0, 0);

        // unary not R2,R7
        v("not_t0",   0, 1, 1, IR_NOT, ST_T0,   25, 20, 0, 1, 0, 0, 0);
        v("not_t1",   0, 0, 1, IR_NOT, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("not_t2",   0, 0, 1, IR_NOT, ST_T2,   23, 21, 0, 0, 0, 0, 0);
        v("not_t3",   0, 0, 1, IR_NOT, ST_T3,    0,  0, 0, 0, 0, 0, 0);
        v("not_t4",   0, 0, 1, IR_NOT, ST_T4,   24,  7, 0, 0, 9, 0, 0);
        v("not_t5",   0, 0, 1, IR_NOT, ST_T5,    2, 19, 0, 0, 0, 1, 0);
        v("not_idle", 0, 0, 1, IR_NOT, ST_IDLE,  0,  0, 0, 0, 0, 0, 0);

        // sub R0,R0,R15: R0 maps to code 26 on both bus and load
        v("sub_t0",   0, 1, 1, IR_SUB, ST_T0,   25, 20, 0, 1, 0, 0, 0);
        v("sub_t1",   0, 0, 1, IR_SUB, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("sub_t2",   0, 0, 1, IR_SUB, ST_T2,   23, 21, 0, 0, 0, 0, 0);
        v("sub_t3",   0, 0, 1, IR_SUB, ST_T3,   27, 26, 0, 0, 0, 0, 0);
        v("sub_t4",   0, 0, 1, IR_SUB, ST_T4,   24, 15, 0, 0, 2, 0, 0);
        v("sub_t5",   0, 0, 1, IR_SUB, ST_T5,   26, 19, 0, 0, 0, 1, 0);
        v("sub_idle", 0, 0, 1, IR_SUB, ST_IDLE,  0,  0, 0, 0, 0, 0, 0);

        // illegal opcode: sticky fault with run held high, only clr exits
        v("bad_t0", 0, 1, 1, IR_BAD, ST_T0,   25, 20, 0, 1, 0, 0, 0);
        v("bad_t1", 0, 1, 1, IR_BAD, ST_T1,   21,  0, 1, 0, 0, 0, 0);
        v("bad_t2", 0, 1, 1, IR_BAD, ST_T2,   23, 21, 0, 0, 0, 0, 0);
        v("bad_t3", 0, 1, 1, IR_BAD, ST_T3,    0,  0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            v("bad_flt", 0, 1, 1, IR_BAD, ST_FAULT, 0, 0, 0, 0, 0, 0, 1);
        v("bad_clr",  1, 1, 1, IR_BAD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
        v("bad_idle", 0, 0, 1, IR_ADD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

        // run held: back-to-back T5->T0, clr lands in the second T4
        v("b2b_t0",  0, 1, 1, IR_ADD, ST_T0, 25, 20, 0, 1, 0, 0, 0);
        v("b2b_t1",  0, 1, 1, IR_ADD, ST_T1, 21,  0, 1, 0, 0, 0, 0);
        v("b2b_t2",  0, 1, 1, IR_ADD, ST_T2, 23, 21, 0, 0, 0, 0, 0);
        v("b2b_t3",  0, 1, 1, IR_ADD, ST_T3, 27,  4, 0, 0, 0, 0, 0);
        v("b2b_t4",  0, 1, 1, IR_ADD, ST_T4, 24,  5, 0, 0, 1, 0, 0);
        v("b2b_t5",  0, 1, 1, IR_ADD, ST_T5,  1, 19, 0, 0, 0, 1, 0);
        v("b2b2_t0", 0, 1, 1, IR_ADD, ST_T0, 25, 20, 0, 1, 0, 0, 0);
        v("b2b2_t1", 0, 1, 1, IR_ADD, ST_T1, 21,  0, 1, 0, 0, 0, 0);
        v("b2b2_t2", 0, 1, 1, IR_ADD, ST_T2, 23, 21, 0, 0, 0, 0, 0);
        v("b2b2_t3", 0, 1, 1, IR_ADD, ST_T3, 27,  4, 0, 0, 0, 0, 0);
        v("b2b2_t4", 0, 1, 1, IR_ADD, ST_T4, 24,  5, 0, 0, 1, 0, 0);
        v("b2b_clr", 1, 1, 1, IR_ADD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
        v("b2b_idle", 0, 0, 1, IR_ADD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);
        v("b2b_idle", 0, 0, 1, IR_ADD, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply_and_check(vecs[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
